fft_input_framer: RTL and testbench
===================================

# fft_input_framer

Serial-to-parallel front end for the 32-point FFT pipeline. It accepts one signed 8-bit Q4.4 ADC sample per valid beat, aligns frames on a start-of-frame marker and sign-extends each sample to Q8.8. It assembles 32 samples into one packed frame word and presents that word to the FFT's parallel `data_in`, with a one-cycle `fft_start` strobe per completed frame. Because the FFT is fully pipelined and accepts a frame every cycle, the framer never stalls on its output.

## Interface
- `N`, 32, points per frame (power of two)
- `WIDTH`, 16, output width per point (Q8.8)
- `ADC_WIDTH`, 8, input sample width (Q4.4)
- `CNT_WIDTH`, 16, width of the frame counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `adc_valid`  in  1  `adc_data` and `adc_sof` qualify this cycle
- `adc_sof`  in  1  this beat is sample 0 of a frame
- `adc_data`  in  ADC_WIDTH  signed Q4.4 sample
- `frame_data`  out  N*WIDTH  packed frame; sample k at `[(N-k)*WIDTH-1 -: WIDTH]` (sample 0 in MSBs)
- `fft_start`  out  1  one-cycle strobe when `frame_data` holds a new frame
- `sync_err`  out  1  one-cycle pulse when a partial frame is discarded
- `frame_count`  out  CNT_WIDTH  completed frames since reset, wraps

## Operation
- Conversion: out = {4{s[7]}, s[7:0], 4'b0}. Value is preserved exactly, so there is no rounding and no saturation.
- Internal sample buffer: N×WIDTH registers plus an index `idx` of width log2(N).
- State IDLE:
  - A beat with `adc_valid && adc_sof` writes buffer[0], sets idx=1 and moves to FILL.
  - A valid beat without `adc_sof` is dropped silently, with no error.
- State FILL (idx 1..N-1):
  - A valid beat without `adc_sof` writes buffer[idx] and increments idx.
  - A valid beat with `adc_sof` is a short frame. Pulse `sync_err`, discard the partial frame, write this sample to buffer[0], set idx=1 and stay in FILL.
  - Accepting the beat at idx=N-1 completes the frame:
    - `frame_data` is loaded with buffer[0..N-2] plus this converted sample.
    - `fft_start` is driven to 1.
    - `frame_count` increments.
    - idx returns to 0 and the state returns to IDLE.
- Cycles with `adc_valid`=0 change nothing except clearing the strobes.
- `frame_data` holds its value until the next frame completes.
- The buffer is never read combinationally to the output. Only completed frames are ever visible on `frame_data`.

## Timing
- Reset values: `frame_data`=0, `fft_start`=0, `sync_err`=0, `frame_count`=0, state IDLE, idx=0, buffer=0.
- Reset asserted mid-FILL discards the partial frame. Outputs clear immediately (asynchronously).
- Latency:
  - `frame_data` and `fft_start` update on the same rising edge that accepts sample N-1, so they are visible in the following cycle.
  - The FFT output appears log2(N)+1 cycles after that.
- `fft_start` is high for exactly one cycle per completed frame and is never high in two consecutive cycles. Minimum frame spacing is N cycles.
- Back-to-back frames: an `adc_sof` beat in the cycle right after completion is accepted as sample 0 with no gap.
- `sync_err` is registered, so it is visible in the cycle after the offending beat. It never coincides with `fft_start`.
- `frame_count` wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- `adc_sof` without `adc_valid` is ignored.

## Structure
- Shared package `fft_pkg`:
  - Constants `N`, `WIDTH`, `ADC_WIDTH`, `FRAC_IN`=4 and `FRAC_OUT`=8.
  - State enum {IDLE, FILL}.
  - Function `q44_to_q88`.
- No sub-module. The design is one FSM, one index counter, a register-array buffer and an output register bank.

## Test plan
- Reset check: with `rst`=1, all outputs read 0. Release reset, send a full 32-beat frame of ramp samples 0x00..0x1F with sof on beat 0. Expect a single `fft_start` pulse. Sample k reads {4{0}}, k, 4'b0 (e.g. k=1 → 0x0010, k=16 → 0x0100). `frame_count`=1.
- Sign/extreme conversion: samples 0x80, 0x7F, 0xFF, 0x10 → 0xF800, 0x07F0, 0xFFF0, 0x0100 in slots 0..3.
- Short frame: sof on beat 0, 10 valid beats, then sof again. Expect `sync_err` pulse one cycle later and no `fft_start`. The next 32 beats produce a frame whose slot 0 equals the second sof sample.
- Gaps and pre-sof garbage: 5 valid beats without sof, then a frame with `adc_valid` toggling 1/0. The garbage is dropped, the frame is correct, and `fft_start` occurs exactly once, 63 cycles after the sof beat.
- Back-to-back: 3 contiguous frames (96 beats). `fft_start` fires at beats 32, 64 and 96, exactly 32 cycles apart. `frame_data` is stable between strobes. `frame_count`=3.
- Reset mid-fill: assert `rst` at beat 20. Outputs go to 0 immediately. After release, a full frame completes normally with `frame_count`=1.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants, state encoding and sample conversion for
//               the 32-point FFT input framer.
//               N         points per frame
//               WIDTH     output width per point (Q8.8)
//               ADC_WIDTH input sample width (Q4.4)
//               FRAC_IN   fractional bits of the ADC sample
//               FRAC_OUT  fractional bits of the framed sample
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int N         = 32;
  localparam int WIDTH     = 16;
  localparam int ADC_WIDTH = 8;
  localparam int FRAC_IN   = 4;
  localparam int FRAC_OUT  = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Q4.4 -> Q8.8: sign-extend the integer part and append zero fraction
  // bits. Every Q4.4 value is exactly representable, so nothing is rounded
  // or saturated.
  function automatic logic [WIDTH-1:0] q44_to_q88(input logic [ADC_WIDTH-1:0] s);
    return {{(WIDTH - ADC_WIDTH - (FRAC_OUT - FRAC_IN)){s[ADC_WIDTH-1]}},
            s,
            {(FRAC_OUT - FRAC_IN){1'b0}}};
  endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_input_framer.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_framer
// Description : Serial-to-parallel front end for the 32-point FFT. Collects
//               one Q4.4 sample per valid beat, aligns on start-of-frame,
//               converts to Q8.8 and publishes each completed frame as one
//               packed word with a single-cycle start strobe.
// Ports       : clk          rising-edge clock
//               rst          asynchronous active-high reset
//               adc_valid    adc_data / adc_sof qualify this cycle
//               adc_sof      this beat is sample 0 of a frame
//               adc_data     signed Q4.4 sample
//               frame_data   packed frame, sample 0 in the MSBs
//               fft_start    one-cycle strobe when a new frame is published
//               sync_err     one-cycle pulse when a partial frame is dropped
//               frame_count  completed frames since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_framer #(
  parameter int N         = 32,
  parameter int WIDTH     = 16,
  parameter int ADC_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adc_valid,
  input  logic                 adc_sof,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [N*WIDTH-1:0]   frame_data,
  output logic                 fft_start,
  output logic                 sync_err,
  output logic [CNT_WIDTH-1:0] frame_count
);

  import fft_pkg::*;

  localparam int IDX_W = $clog2(N);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     buf_q [N];
  logic [WIDTH-1:0]     buf_d [N];
  logic [N*WIDTH-1:0]   frame_q, frame_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     sample_w;

  assign sample_w = q44_to_q88(adc_data);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    frame_d = frame_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (adc_valid) begin
      case (state_q)
        IDLE: begin
          // Beats before a start-of-frame carry no alignment and are dropped.
          if (adc_sof) begin
            buf_d[0] = sample_w;
            idx_d    = IDX_W'(1);
            state_d  = FILL;
          end
        end
        FILL: begin
          if (adc_sof) begin
            // Short frame: restart alignment on this beat.
            err_d    = 1'b1;
            buf_d[0] = sample_w;
            idx_d    = IDX_W'(1);
          end else begin
            buf_d[idx_q] = sample_w;
            if (idx_q == IDX_W'(N - 1)) begin
              // Publish from buf_d so the final sample goes straight into
              // the frame word on the accepting edge.
              for (int k = 0; k < N; k++) begin
                frame_d[(N-k)*WIDTH-1 -: WIDTH] = buf_d[k];
              end
              start_d = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
      frame_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
      start_q <= start_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_data  = frame_q;
  assign fft_start   = start_q;
  assign sync_err    = err_q;
  assign frame_count = cnt_q;

endmodule : fft_input_framer
`default_nettype wire

// File: tb/tb_fft_input_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_input_framer
// Description : Self-checking bench for fft_input_framer. A queue-based frame
//               model predicts every output after every beat; directed steps
//               add the boundary cases (ramp, extremes, short frame, gaps,
//               back-to-back, reset mid-fill).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_framer;

  localparam int N  = 32;
  localparam int W  = 16;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          adc_valid;
  logic          adc_sof;
  logic [7:0]    adc_data;
  logic [FW-1:0] frame_data;
  logic          fft_start;
  logic          sync_err;
  logic [15:0]   frame_count;

  fft_input_framer dut (
    .clk         (clk),
    .rst         (rst),
    .adc_valid   (adc_valid),
    .adc_sof     (adc_sof),
    .adc_data    (adc_data),
    .frame_data  (frame_data),
    .fft_start   (fft_start),
    .sync_err    (sync_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]    mq[$];
  bit            in_frame;
  logic [FW-1:0] m_frame;
  logic          m_start;
  logic          m_err;
  logic [15:0]   m_cnt;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int cyc    = 0;
  int starts[$];

  // Value-level conversion: a Q4.4 code times 16 is the same value in Q8.8.
  function automatic logic [15:0] conv(input logic [7:0] s);
    int v;
    v = int'($signed(s)) * 16;
    return v[15:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    in_frame = 1'b0;
    m_frame  = '0;
    m_start  = 1'b0;
    m_err    = 1'b0;
    m_cnt    = '0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [7:0] d);
    m_start = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (s) begin
        if (in_frame) m_err = 1'b1;
        mq.delete();
        mq.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        mq.push_back(d);
      end
      if (in_frame && mq.size() == N) begin
        for (int k = 0; k < N; k++) m_frame[(N-k)*W-1 -: W] = conv(mq[k]);
        m_start  = 1'b1;
        m_cnt    = m_cnt + 16'd1;
        in_frame = 1'b0;
        mq.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock beat: drive, advance the model, then compare all outputs.
  task automatic beat(input bit v, input bit s, input logic [7:0] d);
    adc_valid = v;
    adc_sof   = s;
    adc_data  = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    cyc++;
    if (fft_start === 1'b1) starts.push_back(cyc);
    chk("fft_start",   {{(FW-1){1'b0}}, fft_start}, {{(FW-1){1'b0}}, m_start});
    chk("sync_err",    {{(FW-1){1'b0}}, sync_err},  {{(FW-1){1'b0}}, m_err});
    chk("frame_count", {{(FW-16){1'b0}}, frame_count}, {{(FW-16){1'b0}}, m_cnt});
    chk("frame_data",  frame_data, m_frame);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk(tag, {{(FW-16){1'b0}}, obs}, {{(FW-16){1'b0}}, exp});
  endtask

  initial begin
    int s0;
    int n0;
    logic [15:0] c0;
    logic [7:0]  d2;
    logic [7:0]  ext [4];

    ext[0] = 8'h80; ext[1] = 8'h7F; ext[2] = 8'hFF; ext[3] = 8'h10;

    // ---- reset state ----
    rst = 1'b1; adc_valid = 1'b0; adc_sof = 1'b0; adc_data = '0;
    model_reset();
    #2;
    chk("rst_frame_data", frame_data, '0);
    chk16("rst_fft_start", {15'd0, fft_start}, 16'd0);
    chk16("rst_sync_err",  {15'd0, sync_err},  16'd0);
    chk16("rst_frame_count", frame_count, 16'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ---- ramp frame ----
    s0 = cyc;
    for (int k = 0; k < N; k++) beat(1'b1, k == 0, 8'(k));
    chk16("ramp_slot1",  frame_data[(N-1)*W-1 -: W],  16'h0010);
    chk16("ramp_slot16", frame_data[(N-16)*W-1 -: W], 16'h0100);
    chk16("ramp_count", frame_count, 16'd1);
    chk16("ramp_nstarts", 16'(starts.size()), 16'd1);
    chk16("ramp_latency", 16'(starts[$] - s0), 16'd32);
    beat(1'b0, 1'b0, 8'($urandom));

    // ---- sign / extreme conversion ----
    for (int k = 0; k < N; k++)
      beat(1'b1, k == 0, (k < 4) ? ext[k] : 8'($urandom));
    chk16("ext_slot0", frame_data[N*W-1 -: W],     16'hF800);
    chk16("ext_slot1", frame_data[(N-1)*W-1 -: W], 16'h07F0);
    chk16("ext_slot2", frame_data[(N-2)*W-1 -: W], 16'hFFF0);
    chk16("ext_slot3", frame_data[(N-3)*W-1 -: W], 16'h0100);

    // ---- short frame ----
    n0 = starts.size();
    for (int k = 0; k < 10; k++) beat(1'b1, k == 0, 8'($urandom));
    d2 = 8'($urandom);
    beat(1'b1, 1'b1, d2);
    chk16("short_err", {15'd0, sync_err}, 16'd1);
    for (int k = 1; k < N; k++) beat(1'b1, 1'b0, 8'($urandom));
    chk16("short_nstarts", 16'(starts.size() - n0), 16'd1);
    chk16("short_slot0", frame_data[N*W-1 -: W], conv(d2));

    // ---- pre-sof garbage and gapped frame ----
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0, 8'($urandom));
    n0 = starts.size();
    s0 = cyc;
    for (int k = 0; k < N; k++) begin
      beat(1'b1, k == 0, 8'($urandom));
      if (k < N - 1) beat(1'b0, 1'($urandom), 8'($urandom));
    end
    beat(1'b0, 1'b0, 8'h00);
    chk16("gap_nstarts", 16'(starts.size() - n0), 16'd1);
    chk16("gap_latency", 16'(starts[$] - s0), 16'd63);

    // ---- back-to-back frames ----
    n0 = starts.size();
    c0 = frame_count;
    s0 = cyc;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) beat(1'b1, k == 0, 8'($urandom));
    beat(1'b0, 1'b0, 8'h00);
    chk16("b2b_nstarts", 16'(starts.size() - n0), 16'd3);
    chk16("b2b_first",   16'(starts[n0] - s0), 16'd32);
    chk16("b2b_gap1",    16'(starts[n0+1] - starts[n0]), 16'd32);
    chk16("b2b_gap2",    16'(starts[n0+2] - starts[n0+1]), 16'd32);
    chk16("b2b_count",   frame_count - c0, 16'd3);

    // ---- randomized traffic ----
    for (int k = 0; k < 600; k++)
      beat(($urandom_range(3, 0) != 0), ($urandom_range(39, 0) == 0), 8'($urandom));

    // ---- reset mid-fill ----
    for (int k = 0; k < 20; k++) beat(1'b1, k == 0, 8'($urandom));
    #1 rst = 1'b1;
    #1;
    chk("mid_frame_data", frame_data, '0);
    chk16("mid_fft_start",   {15'd0, fft_start}, 16'd0);
    chk16("mid_sync_err",    {15'd0, sync_err},  16'd0);
    chk16("mid_frame_count", frame_count, 16'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) beat(1'b1, k == 0, 8'($urandom));
    chk16("mid_after_count", frame_count, 16'd1);
    beat(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fft_input_framer
`default_nettype wire
